// File: rtl/instr_register_alu.sv
// Instruction register file with a built-in ALU: each entry holds an opcode, two operands
// and the expected result. DIV/MOD results come from a multi-cycle restoring divider.
package instr_register_alu_pkg;
    typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;
    typedef struct packed {
        opcode_t            opc;
        operand_t           op_a;
        operand_t           op_b;
        logic signed [63:0] exp_result;
    } instruction_t;
endpackage

module instr_register_alu
    import instr_register_alu_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_en,
    input  operand_t     operand_a,
    input  operand_t     operand_b,
    input  opcode_t      opcode,
    input  address_t     write_pointer,
    input  address_t     read_pointer,
    output instruction_t instruction_word,
    output logic         rd_valid,
    output logic         busy
);

    typedef enum logic {IDLE, DIVIDE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [5:0]         r_count;
    instruction_t       r_mem [DEPTH];
    logic [DEPTH-1:0]   r_pend;

    address_t           r_div_ptr;
    logic               r_div_is_mod;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [31:0]        r_dvd;
    logic [31:0]        r_dvs;
    logic [31:0]        r_rem;

    logic               w_accept;
    logic               w_start;
    logic               w_last;
    logic [31:0]        w_mag_a;
    logic [31:0]        w_mag_b;
    logic signed [63:0] w_a64;
    logic signed [63:0] w_b64;
    logic signed [63:0] w_alu_res;
    logic [32:0]        w_rem_sh;
    logic               w_ge;
    logic [31:0]        w_diff;
    logic [31:0]        w_rem_nxt;
    logic [31:0]        w_quo_nxt;
    logic signed [31:0] w_res32;
    logic signed [63:0] w_div_res;

    assign busy     = (r_state == DIVIDE);
    assign w_accept = load_en && !busy;
    assign w_start  = w_accept && (opcode == DIV || opcode == MOD) && (operand_b != 32'sd0);
    assign w_last   = busy && (r_count == 6'(DIV_CYCLES - 1));

    assign w_a64   = 64'(operand_a);
    assign w_b64   = 64'(operand_b);
    assign w_mag_a = operand_a[31] ? -operand_a : operand_a;
    assign w_mag_b = operand_b[31] ? -operand_b : operand_b;

    always_comb begin
        w_alu_res = '0;
        case (opcode)
            PASSA:   w_alu_res = w_a64;
            PASSB:   w_alu_res = w_b64;
            ADD:     w_alu_res = w_a64 + w_b64;
            SUB:     w_alu_res = w_a64 - w_b64;
            MULT:    w_alu_res = w_a64 * w_b64;
            default: w_alu_res = '0;
        endcase
    end

    // One restoring step: the quotient bits shift in where the dividend bits shift out.
    assign w_rem_sh  = {r_rem, r_dvd[31]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    assign w_diff    = w_rem_sh[31:0] - r_dvs;
    assign w_rem_nxt = w_ge ? w_diff : w_rem_sh[31:0];
    assign w_quo_nxt = {r_dvd[30:0], w_ge};
    assign w_res32   = r_div_is_mod ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                                    : (r_neg_q ? -w_quo_nxt : w_quo_nxt);
    assign w_div_res = 64'(w_res32);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = DIVIDE;
            DIVIDE:  if (w_last)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count      <= '0;
            r_div_ptr    <= '0;
            r_div_is_mod <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_dvd        <= '0;
            r_dvs        <= '0;
            r_rem        <= '0;
        end else if (w_start) begin
            r_count      <= '0;
            r_div_ptr    <= write_pointer;
            r_div_is_mod <= (opcode == MOD);
            r_neg_q      <= operand_a[31] ^ operand_b[31];
            r_neg_r      <= operand_a[31];
            r_dvd        <= w_mag_a;
            r_dvs        <= w_mag_b;
            r_rem        <= '0;
        end else if (busy) begin
            r_count      <= r_count + 6'd1;
            r_dvd        <= w_quo_nxt;
            r_rem        <= w_rem_nxt;
        end
    end

    // Writes and divider completion never coincide: completion only happens while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_accept && write_pointer == address_t'(i)) begin
                    r_mem[i].opc        <= opcode;
                    r_mem[i].op_a       <= operand_a;
                    r_mem[i].op_b       <= operand_b;
                    r_mem[i].exp_result <= w_alu_res;
                    r_pend[i]           <= w_start;
                end else if (w_last && r_div_ptr == address_t'(i)) begin
                    r_mem[i].exp_result <= w_div_res;
                    r_pend[i]           <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instruction_word <= '0;
            rd_valid         <= 1'b0;
        end else begin
            instruction_word <= r_mem[read_pointer];
            rd_valid         <= ~r_pend[read_pointer];
        end
    end

endmodule

// File: tb/tb_instr_register_alu.sv
// Directed bench for instr_register_alu: ALU ops, iterative DIV/MOD, busy lockout and reset abort.
module tb_instr_register_alu;
    import instr_register_alu_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         load_en = 1'b0;
    operand_t     operand_a = '0;
    operand_t     operand_b = '0;
    opcode_t      opcode = ZERO;
    address_t     write_pointer = '0;
    address_t     read_pointer = '0;
    instruction_t instruction_word;
    logic         rd_valid;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    instr_register_alu #(.DEPTH(32), .DIV_CYCLES(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_en          (load_en),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .opcode           (opcode),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .rd_valid         (rd_valid),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    function automatic instruction_t mk(opcode_t o, int a, int b, longint r);
        instruction_t t;
        t.opc        = o;
        t.op_a       = a;
        t.op_b       = b;
        t.exp_result = r;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input instruction_t obs, input instruction_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic wr(input opcode_t o, input int a, input int b, input address_t p);
        opcode        = o;
        operand_a     = a;
        operand_b     = b;
        write_pointer = p;
        load_en       = 1'b1;
        tick();
        load_en       = 1'b0;
    endtask

    task automatic rd(input address_t p);
        read_pointer = p;
        tick();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_word("reset_word", instruction_word, '0);
        chk_bit("reset_rd_valid", rd_valid, 1'b0);
        chk_bit("reset_busy", busy, 1'b0);
        reset_n = 1'b1;

        // ADD on the first edge after reset; same-edge read sees the old (empty) entry
        read_pointer = 5'd0;
        wr(ADD, 7, 9, 5'd0);
        chk_word("rbw_word", instruction_word, '0);
        chk_bit("rbw_rd_valid", rd_valid, 1'b1);
        rd(5'd0);
        chk_word("add_7_9", instruction_word, mk(ADD, 7, 9, 16));
        chk_bit("add_rd_valid", rd_valid, 1'b1);

        wr(SUB, 3, 12, 5'd5);
        rd(5'd5);
        chk_word("sub_3_12", instruction_word, mk(SUB, 3, 12, -9));
        chk_bit("sub_hex", instruction_word.exp_result == 64'hFFFF_FFFF_FFFF_FFF7, 1'b1);

        wr(MULT, -4, 15, 5'd6);
        rd(5'd6);
        chk_word("mult_m4_15", instruction_word, mk(MULT, -4, 15, -60));

        wr(MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd7);
        rd(5'd7);
        chk_word("mult_wide", instruction_word,
                 mk(MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001));

        wr(PASSB, 1, -2, 5'd8);
        rd(5'd8);
        chk_word("passb_sext", instruction_word, mk(PASSB, 1, -2, -2));

        wr(PASSA, -5, 3, 5'd8);
        rd(5'd8);
        chk_word("passa_overwrite", instruction_word, mk(PASSA, -5, 3, -5));

        wr(ZERO, 5, 6, 5'd8);
        rd(5'd8);
        chk_word("zero_op", instruction_word, mk(ZERO, 5, 6, 0));

        // DIV -17/5 into entry 2 at E0, with a refused write at E10 and a peek at entry 3 at E20
        read_pointer = 5'd2;
        wr(DIV, -17, 5, 5'd2);
        chk_bit("div_busy_e0", busy, 1'b1);
        chk_bit("div_rd_valid_e0", rd_valid, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            if (k == 10) begin
                opcode = ADD; operand_a = 1; operand_b = 2; write_pointer = 5'd3; load_en = 1'b1;
            end else begin
                load_en = 1'b0;
            end
            read_pointer = (k == 20) ? 5'd3 : 5'd2;
            tick();
            if (k == 5) begin
                chk_word("div_pending_word", instruction_word, mk(DIV, -17, 5, 0));
            end
            if (k == 20) begin
                chk_word("busy_write_ignored", instruction_word, '0);
                chk_bit("busy_write_rd_valid", rd_valid, 1'b1);
            end else if (k < 32) begin
                chk_bit("div_busy_mid", busy, 1'b1);
                chk_bit("div_rd_valid_mid", rd_valid, 1'b0);
            end else begin
                chk_bit("div_busy_e32", busy, 1'b0);
                chk_bit("div_rd_valid_e32", rd_valid, 1'b0);
            end
        end
        read_pointer = 5'd2;
        wr(ADD, 1, 2, 5'd3);
        chk_word("div_m17_5", instruction_word, mk(DIV, -17, 5, -3));
        chk_bit("div_rd_valid_done", rd_valid, 1'b1);
        chk_bit("busy_after_retry", busy, 1'b0);
        rd(5'd3);
        chk_word("retry_e33_accepted", instruction_word, mk(ADD, 1, 2, 3));

        // Remainder -17%5 with inputs scrambled after E0
        wr(MOD, -17, 5, 5'd4);
        opcode = ADD; operand_a = 999; operand_b = 1; write_pointer = 5'd9;
        repeat (32) tick();
        chk_bit("mod_busy_done", busy, 1'b0);
        rd(5'd4);
        chk_word("mod_m17_5", instruction_word, mk(MOD, -17, 5, -2));
        rd(5'd9);
        chk_word("capture_isolated", instruction_word, '0);

        wr(DIV, 100, -7, 5'd10);
        repeat (32) tick();
        rd(5'd10);
        chk_word("div_100_m7", instruction_word, mk(DIV, 100, -7, -14));
        wr(MOD, 100, -7, 5'd11);
        repeat (32) tick();
        rd(5'd11);
        chk_word("mod_100_m7", instruction_word, mk(MOD, 100, -7, 2));

        // Divide by zero completes immediately
        wr(DIV, 10, 0, 5'd12);
        chk_bit("div0_busy", busy, 1'b0);
        rd(5'd12);
        chk_word("div0_result", instruction_word, mk(DIV, 10, 0, 0));
        chk_bit("div0_rd_valid", rd_valid, 1'b1);
        wr(MOD, 10, 0, 5'd12);
        chk_bit("mod0_busy", busy, 1'b0);
        rd(5'd12);
        chk_word("mod0_result", instruction_word, mk(MOD, 10, 0, 0));

        // Reset pulsed at E15 of a DIV aborts it
        read_pointer = 5'd13;
        wr(DIV, 20, 3, 5'd13);
        repeat (14) tick();
        chk_bit("pre_abort_busy", busy, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_word("abort_word", instruction_word, '0);
        chk_bit("abort_rd_valid", rd_valid, 1'b0);
        chk_bit("abort_busy", busy, 1'b0);
        tick();
        reset_n = 1'b1;
        wr(ADD, 2, 3, 5'd14);
        repeat (40) tick();
        chk_bit("abort_no_busy", busy, 1'b0);
        chk_word("abort_no_late_write", instruction_word, '0);
        chk_bit("abort_entry_valid", rd_valid, 1'b1);
        rd(5'd14);
        chk_word("first_write_after_reset", instruction_word, mk(ADD, 2, 3, 5));
        rd(5'd0);
        chk_word("reset_cleared_entry0", instruction_word, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_register_alu.md
INSTR_REGISTER_ALU -- requirements
Module: instr_register_alu

Interface
REQ-001 SHALL declare parameter DEPTH, default 32, number of instruction entries (address_t width 5).
REQ-002 SHALL declare parameter DIV_CYCLES, default 32, iterative divider steps for DIV/MOD.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load_en, input, 1, write request.
REQ-006 SHALL have port operand_a, input, 32 (operand_t, signed), write operand A.
REQ-007 SHALL have port operand_b, input, 32 (operand_t, signed), write operand B.
REQ-008 SHALL have port opcode, input, 3 (opcode_t: ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD), write opcode.
REQ-009 SHALL have port write_pointer, input, 5 (address_t), write entry index.
REQ-010 SHALL have port read_pointer, input, 5 (address_t), read entry index.
REQ-011 SHALL have port instruction_word, output, instruction_t {opc, op_a, op_b, exp_result[63:0] signed}, registered read data.
REQ-012 SHALL have port rd_valid, output, 1, high when instruction_word holds a completed result.
REQ-013 SHALL have port busy, output, 1, high while a DIV/MOD is in progress; writes are refused while high.

Function
REQ-014 Write accepted on a rising edge where load_en=1 and busy=0; load_en while busy=1 SHALL be ignored with no state change.
REQ-015 Accepted write SHALL store opc, op_a, op_b into entry write_pointer on the accepting edge.
REQ-016 ZERO/PASSA/PASSB/ADD/SUB/MULT SHALL store exp_result on the accepting edge: 0, sign-extended a, sign-extended b, a+b, a-b, a*b (all 64-bit signed, no overflow loss).
REQ-017 DIV/MOD with op_b=0 SHALL store exp_result=0 on the accepting edge; busy stays 0.
REQ-018 DIV/MOD with op_b!=0 SHALL set the entry's pending flag and exp_result=0 on the accepting edge E0, assert busy from E0, and run DIV_CYCLES restoring-division steps on edges E1..E32.
REQ-019 Division SHALL run on magnitudes with sign fix-up: quotient truncated toward zero, remainder takes the dividend's sign (SystemVerilog / and % semantics); result sign-extended to 64 bits.
REQ-020 On edge E32 the result SHALL be written to the captured entry index, pending cleared, busy deasserted; next write acceptable at E33.
REQ-021 Divider SHALL capture write_pointer, operands, and opcode at E0; later input changes SHALL NOT affect it.
REQ-022 FSM states: IDLE (busy=0) -> DIVIDE on accept of non-zero-divisor DIV/MOD; DIVIDE -> IDLE when step counter reaches DIV_CYCLES; 6-bit counter.
REQ-023 Read: every rising edge, instruction_word <= entry[read_pointer], rd_valid <= ~pending[read_pointer]; one-cycle latency.
REQ-024 Read and write (or divider completion) to the same entry on the same edge SHALL return the pre-edge contents (read-before-write).
REQ-025 Writing an entry overwrites it fully, including clearing any stale result; unwritten entries read as {ZERO,0,0,0} with rd_valid=1.

Reset
REQ-026 reset_n=0 SHALL immediately clear all entries to {ZERO,0,0,0}, all pending flags, instruction_word=0, rd_valid=0, busy=0, FSM=IDLE, counter=0.
REQ-027 Reset asserted mid-divide SHALL abort the operation; no result is written after reset release.
REQ-028 First write SHALL be accepted on the first rising edge after reset_n rises.

Verification
REQ-029 Write ADD a=7 b=9 to entry 0, read ptr 0 -> next edge instruction_word={ADD,7,9,16}, rd_valid=1.
REQ-030 Write SUB a=3 b=12 to entry 5, read -> exp_result=-9 (64-bit 0xFFFF_FFFF_FFFF_FFF7); MULT a=-4 b=15 -> -60.
REQ-031 Write DIV a=-17 b=5 to entry 2 at E0; read ptr 2 -> rd_valid=0 until after E32, then exp_result=-3; MOD same operands -> -2; busy high E0..E32.
REQ-032 DIV in progress, load_en=1 with ADD to entry 3 at E10 -> ignored, entry 3 still {ZERO,0,0,0}; retry at E33 -> accepted.
REQ-033 DIV a=10 b=0 -> exp_result=0 on accepting edge, busy never asserts; MOD a=10 b=0 -> 0.
REQ-034 reset_n pulsed low at E15 of a DIV -> all outputs 0, busy=0; after release, entry read returns {ZERO,0,0,0}, no late result write.
